// File: rtl/shift_rows_seq.sv
// shift_rows_seq: sequential forward AES ShiftRows, one row rotation per step.
// Latency: 3*ROW_STEP_CYCLES clk cycles from the start-sampling edge to done high.
// Backpressure: result and done are held in DONE until ack; start is only honoured in IDLE.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     capture request, honoured only in IDLE
//   state_in  16-byte AES state, byte k = bits [8k:8k+7], byte index = 4*col + row
//   ack       consumer acknowledge, honoured only in DONE
//   state_out registered ShiftRows result
//   busy      high in every state except IDLE
//   done      high while state_out holds an unacknowledged result
module shift_rows_seq #(
  parameter int ROW_STEP_CYCLES = 1  // cycles spent per row step, 1..15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] state_in,
  input  logic         ack,
  output logic [0:127] state_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW1 = 3'd1,
    ROW2 = 3'd2,
    ROW3 = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [3:0] STEP_LAST = 4'(ROW_STEP_CYCLES - 1);

  state_t       state;
  state_t       state_nxt;
  logic [0:127] work;
  logic [3:0]   step_cnt;
  logic         step_end;

  assign step_end = (step_cnt == STEP_LAST);

  // Rotate row 'row' of a column-major state left by 'row' byte positions:
  // byte (row, c) takes byte (row, (c + row) mod 4).
  function automatic logic [0:127] rotate_row(input logic [0:127] s, input int row);
    logic [0:127] r;
    r = s;
    for (int c = 0; c < 4; c++) begin
      r[8*(4*c + row) +: 8] = s[8*(4*((c + row) % 4) + row) +: 8];
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = ROW1;
      ROW1:    if (step_end) state_nxt = ROW2;
      ROW2:    if (step_end) state_nxt = ROW3;
      ROW3:    if (step_end) state_nxt = DONE;
      DONE:    if (ack)      state_nxt = IDLE;  // start in DONE is deliberately ignored
      default:               state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: working register, step counter and result register.
  // Row 0 never moves, so it needs no step of its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      step_cnt  <= '0;
      state_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work     <= state_in;
            step_cnt <= '0;
          end
        end
        ROW1: begin
          if (step_end) begin
            work     <= rotate_row(work, 1);
            step_cnt <= '0;
          end else begin
            step_cnt <= step_cnt + 4'd1;
          end
        end
        ROW2: begin
          if (step_end) begin
            work     <= rotate_row(work, 2);
            step_cnt <= '0;
          end else begin
            step_cnt <= step_cnt + 4'd1;
          end
        end
        ROW3: begin
          if (step_end) begin
            // state_out only ever changes here, so no partial result can leak out
            work      <= rotate_row(work, 3);
            state_out <= rotate_row(work, 3);
            step_cnt  <= '0;
          end else begin
            step_cnt <= step_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_seq.sv
// tb_shift_rows_seq: directed and random checks of shift_rows_seq at ROW_STEP_CYCLES 1 and 4.
// Latency: not applicable (testbench).
// Backpressure: not applicable (testbench).
module tb_shift_rows_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic         ack;
  logic [0:127] state_in;
  logic [0:127] state_out;
  logic         busy;
  logic         done;

  logic         start4;
  logic         ack4;
  logic [0:127] state_in4;
  logic [0:127] state_out4;
  logic         busy4;
  logic         done4;

  int checks;
  int errors;

  shift_rows_seq dut (
    .clk(clk), .rst(rst), .start(start), .state_in(state_in), .ack(ack),
    .state_out(state_out), .busy(busy), .done(done)
  );

  shift_rows_seq #(.ROW_STEP_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .state_in(state_in4), .ack(ack4),
    .state_out(state_out4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ShiftRows: byte k is the k-th byte from the left of the hex literal.
  function automatic logic [127:0] ref_sr(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] ref_inv_sr(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  localparam logic [127:0] VEC_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RES_A = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] VEC_B = 128'h00112233445566778899aabbccddeeff;
  // Hand-derived: row r of VEC_B rotated left by r.
  localparam logic [127:0] RES_B = 128'h0055aaff4499ee3388dd2277cc1166bb;

  initial begin
    logic [127:0] held;
    logic [127:0] rv;
    int           n;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;  ack = 1'b0;  state_in = '0;
    start4 = 1'b0; ack4 = 1'b0; state_in4 = '0;

    tick();
    tick();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_out", state_out, '0);
    check("reset_busy4", busy4, 1'b0);
    rst = 1'b0;
    tick();

    // Basic operation at the default step length, 3-cycle latency.
    state_in = VEC_A;
    start = 1'b1;
    tick();
    start = 1'b0;
    state_in = '1;  // later input changes must not disturb the capture
    check("a_row1_busy", busy, 1'b1);
    check("a_row1_done", done, 1'b0);
    tick();
    check("a_row2_done", done, 1'b0);
    check("a_row2_out", state_out, '0);
    tick();
    check("a_row3_busy", busy, 1'b1);
    check("a_row3_done", done, 1'b0);
    tick();
    check("a_done", done, 1'b1);
    check("a_busy", busy, 1'b1);
    check("a_out", state_out, RES_A);

    // Result held while ack is low; start during DONE alone is ignored too.
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      check("hold_done", done, 1'b1);
      check("hold_out", state_out, RES_A);
    end
    start = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_done", done, 1'b0);
    check("ack_busy", busy, 1'b0);
    check("ack_out", state_out, RES_A);
    // ack outside DONE has no effect
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("idle_ack_busy", busy, 1'b0);

    // start and ack together in DONE: back to IDLE with no new capture.
    state_in = VEC_B;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("b_done", done, 1'b1);
    check("b_out", state_out, RES_B);
    state_in = VEC_A;
    start = 1'b1;
    ack = 1'b1;
    tick();
    start = 1'b0;
    ack = 1'b0;
    check("sa_busy", busy, 1'b0);
    check("sa_done", done, 1'b0);
    tick();
    check("sa_no_capture", busy, 1'b0);
    check("sa_out_kept", state_out, RES_B);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("sa_restart_done", done, 1'b1);
    check("sa_restart_out", state_out, RES_A);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // ROW_STEP_CYCLES=4: done exactly 12 cycles after the start edge;
    // start and state_in changes during ROW2 ignored.
    state_in4 = VEC_A;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 5 || i == 6) begin
        start4 = 1'b1;
        state_in4 = VEC_B;
      end else begin
        start4 = 1'b0;
      end
      tick();
      check($sformatf("s4_done_%0d", i), done4, (i == 12));
      check($sformatf("s4_busy_%0d", i), busy4, 1'b1);
    end
    start4 = 1'b0;
    check("s4_out", state_out4, RES_A);
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    check("s4_ack_busy", busy4, 1'b0);

    // Asynchronous reset during ROW2.
    state_in = VEC_B;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("r_in_row2", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("r_busy", busy, 1'b0);
    check("r_done", done, 1'b0);
    check("r_out", state_out, '0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("r_after_out", state_out, '0);
    check("r_after_busy", busy, 1'b0);
    state_in = VEC_B;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("r_restart_done", done, 1'b1);
    check("r_restart_out", state_out, RES_B);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Random scoreboard.
    for (int op = 0; op < 1000; op++) begin
      rv = {$urandom, $urandom, $urandom, $urandom};
      state_in = rv;
      start = 1'b1;
      tick();
      start = 1'b0;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      n = 0;
      while (!done && n < 10) begin
        tick();
        n++;
      end
      check("rnd_timeout", done, 1'b1);
      check("rnd_latency", n, 3);
      held = state_out;
      check("rnd_out", held, ref_sr(rv));
      check("rnd_inverse", ref_inv_sr(held), rv);
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_rows_seq.md
SHIFT_ROWS_SEQ -- requirements
Module: shift_rows_seq

Interface
REQ-001 Parameter: ROW_STEP_CYCLES, default 1, number of clk cycles spent on each row-rotation step; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all sequential logic.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to process state_in; sampled on clk rising edge.
REQ-005 state_in  input  [0:127]  16-byte AES state, byte k = bits [8k:8k+7], column-major, byte index = 4*col + row.
REQ-006 ack  input  1  consumer acknowledge of the result while done is high.
REQ-007 state_out  output  [0:127]  forward-ShiftRows result, registered.
REQ-008 busy  output  1  high from capture until return to IDLE.
REQ-009 done  output  1  high while state_out holds a fresh, unacknowledged result.

Function
REQ-010 The block SHALL implement forward AES ShiftRows: out byte (r, c) = in byte (r, (c + r) mod 4), r, c in 0..3.
REQ-011 FSM states SHALL be IDLE, ROW1, ROW2, ROW3, DONE, encoded in a registered state vector.
REQ-012 In IDLE with start=1 at an edge, the block SHALL capture state_in into an internal working register, clear the step counter, and enter ROW1.
REQ-013 Row 0 SHALL be copied unchanged; ROW1, ROW2 and ROW3 SHALL rotate row 1, 2 and 3 of the working register left by 1, 2 and 3 byte positions respectively.
REQ-014 Each ROWn state SHALL last exactly ROW_STEP_CYCLES cycles, counted by a step counter; the rotation SHALL be applied at the last edge of that state, together with the transition to the next state.
REQ-015 On the ROW3 to DONE transition, state_out SHALL be loaded with the final working register and done SHALL go high on the same edge.
REQ-016 Latency SHALL be 3*ROW_STEP_CYCLES cycles from the start-sampling edge to done high (3 cycles at default).
REQ-017 busy SHALL be high in ROW1, ROW2, ROW3 and DONE, and low only in IDLE.
REQ-018 In DONE, done and state_out SHALL hold until ack=1 is sampled; that edge SHALL return the FSM to IDLE and clear done.
REQ-019 start SHALL be ignored in every state except IDLE, including DONE with start and ack high together; the requester must reassert start in IDLE.
REQ-020 ack SHALL be ignored outside DONE.
REQ-021 state_in changes after the capture edge SHALL NOT affect the result in progress.
REQ-022 state_out SHALL change only on entry to DONE or on reset, and SHALL keep the last result while in IDLE.

Reset
REQ-023 rst=1 SHALL asynchronously force IDLE, state_out=128'h0, busy=0, done=0, and clear the working register and step counter.
REQ-024 rst asserted mid-operation (any ROWn or DONE) SHALL abort the operation with no partial result appearing on state_out.
REQ-025 After rst deasserts, the first start sampled in IDLE SHALL begin a normal operation.

Verification
REQ-026 Default parameter; state_in = 000102030405060708090a0b0c0d0e0f, start pulse 1 cycle -> done high 3 cycles later, state_out = 00050a0f04090e03080d02070c01060b, busy high throughout.
REQ-027 Hold ack=0 for 10 cycles after done -> done and state_out stable; ack=1 for 1 cycle -> done=0 and busy=0 next cycle; state_out unchanged.
REQ-028 ROW_STEP_CYCLES=4, same vector -> done exactly 12 cycles after the start edge, same result; start pulses and state_in changes during ROW2 are ignored.
REQ-029 Assert rst during ROW2 -> busy=0, done=0 and state_out=0 immediately (asynchronous); a later start gives the correct result.
REQ-030 In DONE, drive start=1 and ack=1 together -> return to IDLE with no new capture; start reasserted in IDLE -> new result after 3 cycles.
REQ-031 Random-vector scoreboard of at least 1000 operations -> state_out matches the REQ-010 reference model, and applying the inverse ShiftRows to state_out returns state_in.
